// File: rtl/prt_scaler_tg.sv
// prt_scaler_tg: video timing generator fed by the cyclic VPS parameter stream.
// A shadow bank follows the stream continuously. The active bank drives the H/V counters and
// reloads only on lock-up or at frame end. HS/VS/DE/X/Y are registered one cycle after the
// counter state they describe.
// Optional feature macro: PRT_SCALER_TG_SOF_EN adds TG_SOF_OUT, a start-of-frame pulse.
module prt_scaler_tg #(
  parameter int unsigned P_IDX_WIDTH = 4,
  parameter int unsigned P_DAT_WIDTH = 16
) (
  input  logic                   VID_CLK_IN,
  input  logic                   VID_RST_IN,
  input  logic                   CTL_RUN_IN,
  input  logic [P_IDX_WIDTH-1:0] VPS_IDX_IN,
  input  logic [P_DAT_WIDTH-1:0] VPS_DAT_IN,
  input  logic                   VPS_VLD_IN,
  output logic                   TG_HS_OUT,
  output logic                   TG_VS_OUT,
  output logic                   TG_DE_OUT,
  output logic [P_DAT_WIDTH-1:0] TG_X_OUT,
  output logic [P_DAT_WIDTH-1:0] TG_Y_OUT,
  output logic                   TG_LOCK_OUT
`ifdef PRT_SCALER_TG_SOF_EN
  ,
  output logic                   TG_SOF_OUT
`endif
);

  localparam int unsigned W      = P_DAT_WIDTH;
  // Words 0..7 are timing values; word 8 carries the two polarity flags.
  localparam int unsigned NumTim = 8;

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] shadow_tim [NumTim];
  logic [1:0]   shadow_pol;
  logic [W-1:0] active_tim [NumTim];
  logic [1:0]   active_pol;
  logic [W-1:0] h_q, h_d, v_q, v_d;

  logic         sweep_end, run_ok, bank_load;
  logic         h_wrap, v_wrap, frame_end;
  logic         hs_raw, vs_raw, de_h, de_v, de_raw;
  logic [W-1:0] htotal, hact, hstart, hsw, vtotal, vact, vstart, vsw;
  logic [W:0]   h_ext, v_ext;

  assign htotal = active_tim[0];
  assign hact   = active_tim[1];
  assign hstart = active_tim[2];
  assign hsw    = active_tim[3];
  assign vtotal = active_tim[4];
  assign vact   = active_tim[5];
  assign vstart = active_tim[6];
  assign vsw    = active_tim[7];

  // Highest index closes a sweep, so every parameter word has been seen at least once.
  assign sweep_end = VPS_VLD_IN && (VPS_IDX_IN == {P_IDX_WIDTH{1'b1}});

  // Counter comparisons are one bit wider so htotal/vtotal of 0 or 1 simply wrap every step
  // and hstart+hact / vstart+vact never wrap.
  assign h_ext     = {1'b0, h_q};
  assign v_ext     = {1'b0, v_q};
  assign h_wrap    = (h_ext + (W+1)'(1)) >= {1'b0, htotal};
  assign v_wrap    = (v_ext + (W+1)'(1)) >= {1'b0, vtotal};
  assign frame_end = h_wrap && v_wrap;

  assign hs_raw = h_q < hsw;
  assign vs_raw = v_q < vsw;
  assign de_h   = (h_ext >= {1'b0, hstart}) && (h_ext < ({1'b0, hstart} + {1'b0, hact}));
  assign de_v   = (v_ext >= {1'b0, vstart}) && (v_ext < ({1'b0, vstart} + {1'b0, vact}));
  assign de_raw = de_h && de_v;

  // Shadow bank: follows every valid VPS word regardless of FSM state.
  always_ff @(posedge VID_CLK_IN or negedge VID_RST_IN) begin
    if (!VID_RST_IN) begin
      for (int i = 0; i < NumTim; i++) shadow_tim[i] <= '0;
      shadow_pol <= '0;
    end else if (VPS_VLD_IN) begin
      for (int i = 0; i < NumTim; i++) begin
        if (VPS_IDX_IN == P_IDX_WIDTH'(i)) shadow_tim[i] <= VPS_DAT_IN;
      end
      if (VPS_IDX_IN == P_IDX_WIDTH'(NumTim)) shadow_pol <= VPS_DAT_IN[1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge VID_CLK_IN or negedge VID_RST_IN) begin
    if (!VID_RST_IN) state_q <= StIdle;
    else             state_q <= state_d;
  end

  // FSM next state; dropping run wins from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (CTL_RUN_IN) state_d = StLoad;
      StLoad:  if (sweep_end) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
    if (!CTL_RUN_IN) state_d = StIdle;
  end

  // FSM outputs: lock indication, run qualifier and active-bank reload strobe.
  always_comb begin
    TG_LOCK_OUT = (state_q == StRun);
    run_ok      = (state_q == StRun) && CTL_RUN_IN;
    bank_load   = ((state_q == StLoad) && (state_d == StRun)) || (run_ok && frame_end);
  end

  // Active bank: reloaded from shadow only at lock-up or frame end.
  always_ff @(posedge VID_CLK_IN or negedge VID_RST_IN) begin
    if (!VID_RST_IN) begin
      for (int i = 0; i < NumTim; i++) active_tim[i] <= '0;
      active_pol <= '0;
    end else if (bank_load) begin
      for (int i = 0; i < NumTim; i++) active_tim[i] <= shadow_tim[i];
      active_pol <= shadow_pol;
    end
  end

  // Counter next state: held at zero unless running.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_ok && !frame_end) begin
      if (h_wrap) begin
        v_d = v_q + W'(1);
      end else begin
        h_d = h_q + W'(1);
        v_d = v_q;
      end
    end
  end

  // H/V counter registers.
  always_ff @(posedge VID_CLK_IN or negedge VID_RST_IN) begin
    if (!VID_RST_IN) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Registered timing outputs; qualified by run so a dropped run blanks them on the next edge.
  always_ff @(posedge VID_CLK_IN or negedge VID_RST_IN) begin
    if (!VID_RST_IN) begin
      TG_HS_OUT <= 1'b0;
      TG_VS_OUT <= 1'b0;
      TG_DE_OUT <= 1'b0;
      TG_X_OUT  <= '0;
      TG_Y_OUT  <= '0;
    end else begin
      TG_HS_OUT <= run_ok && (hs_raw ^ ~active_pol[0]);
      TG_VS_OUT <= run_ok && (vs_raw ^ ~active_pol[1]);
      TG_DE_OUT <= run_ok && de_raw;
      TG_X_OUT  <= (run_ok && de_raw) ? (h_q - hstart) : '0;
      TG_Y_OUT  <= (run_ok && de_raw) ? (v_q - vstart) : '0;
    end
  end

`ifdef PRT_SCALER_TG_SOF_EN
  // Start-of-frame pulse, aligned with the output cycle of h=0, v=0.
  always_ff @(posedge VID_CLK_IN or negedge VID_RST_IN) begin
    if (!VID_RST_IN) TG_SOF_OUT <= 1'b0;
    else             TG_SOF_OUT <= run_ok && (h_q == '0) && (v_q == '0);
  end
`endif

endmodule

// File: tb/tb_prt_scaler_tg.sv
// Scoreboarded bench for prt_scaler_tg: a frame-position model predicts each output cycle,
// a monitor compares the DUT against the predictions one cycle at a time.
module tb_prt_scaler_tg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [3:0]  idx = '0;
  logic [15:0] dat = '0;
  logic        vld = 1'b0;
  logic        hs, vs, de, lock, sof;
  logic [15:0] x, y;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic        lock;
    logic        hs;
    logic        vs;
    logic        de;
    logic        sof;
    logic [15:0] x;
    logic [15:0] y;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  prt_scaler_tg dut (
    .VID_CLK_IN (clk),
    .VID_RST_IN (rst_n),
    .CTL_RUN_IN (run),
    .VPS_IDX_IN (idx),
    .VPS_DAT_IN (dat),
    .VPS_VLD_IN (vld),
    .TG_HS_OUT  (hs),
    .TG_VS_OUT  (vs),
    .TG_DE_OUT  (de),
    .TG_X_OUT   (x),
    .TG_Y_OUT   (y),
    .TG_LOCK_OUT(lock)
`ifdef PRT_SCALER_TG_SOF_EN
    ,
    .TG_SOF_OUT (sof)
`endif
  );

`ifndef PRT_SCALER_TG_SOF_EN
  assign sof = 1'b0;
`endif

  // ---------------- reference model ----------------
  // Position in the frame is a single cycle index t; h and v are derived from it.
  int unsigned m_shadow[9];
  int unsigned m_act[9];
  int          m_st;   // 0 idle, 1 waiting for a full sweep, 2 running
  int unsigned m_t;

  task automatic model_step();
    obs_t        e;
    int unsigned ht, vt, h, v, snap[9];
    bit          running;
    e = '0;
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        m_shadow[i] = 0;
        m_act[i]    = 0;
      end
      m_st = 0;
      m_t  = 0;
      exp_q.push_back(e);
      return;
    end
    ht = (m_act[0] < 2) ? 1 : m_act[0];
    vt = (m_act[4] < 2) ? 1 : m_act[4];
    h  = m_t % ht;
    v  = m_t / ht;
    running = (m_st == 2) && run;
    if (running) begin
      e.hs = ((h < m_act[3]) ? 1'b1 : 1'b0) == m_act[8][0];
      e.vs = ((v < m_act[7]) ? 1'b1 : 1'b0) == m_act[8][1];
      e.de = (h >= m_act[2]) && (h < m_act[2] + m_act[1]) &&
             (v >= m_act[6]) && (v < m_act[6] + m_act[5]);
      if (e.de) begin
        e.x = 16'(h - m_act[2]);
        e.y = 16'(v - m_act[6]);
      end
`ifdef PRT_SCALER_TG_SOF_EN
      e.sof = (m_t == 0);
`endif
    end
    snap = m_shadow;
    if (!run) begin
      m_st = 0;
      m_t  = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      if (vld && idx == 4'd15) begin
        m_st  = 2;
        m_t   = 0;
        m_act = snap;
      end
    end else begin
      if (m_t == ht * vt - 1) begin
        m_t   = 0;
        m_act = snap;
      end else begin
        m_t++;
      end
    end
    if (vld && idx < 4'd9) m_shadow[idx] = {16'd0, dat};
    e.lock = (m_st == 2);
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{lock: lock, hs: hs, vs: vs, de: de, sof: sof, x: x, y: y};
        n_checks++;
        if (a !== e) begin
          n_fails++;
          $display("FAIL outputs @%0t: got lock=%b hs=%b vs=%b de=%b sof=%b x=%0d y=%0d, want lock=%b hs=%b vs=%b de=%b sof=%b x=%0d y=%0d",
                   $time, a.lock, a.hs, a.vs, a.de, a.sof, a.x, a.y,
                   e.lock, e.hs, e.vs, e.de, e.sof, e.x, e.y);
        end
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic check_reset_state(input string tag);
    n_checks++;
    if (hs !== 1'b0 || vs !== 1'b0 || de !== 1'b0 || lock !== 1'b0 ||
        x !== 16'd0 || y !== 16'd0) begin
      n_fails++;
      $display("FAIL reset state (%s) @%0t: lock=%b hs=%b vs=%b de=%b x=%0d y=%0d",
               tag, $time, lock, hs, vs, de, x, y);
    end
  endtask

  // ---------------- stimulus ----------------
  int unsigned cfg[9];

  task automatic set_cfg(input int unsigned ht, ha, hs0, hw, vt, va, vs0, vw, fl);
    cfg = '{ht, ha, hs0, hw, vt, va, vs0, vw, fl};
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      vld = 1'b0;
      idx = 4'($urandom);
      dat = 16'($urandom);
      @(negedge clk);
    end
  endtask

  // Waits up to max_cycles for lock; reports a failure if the wait expires.
  task automatic wait_lock(input int max_cycles);
    int n;
    n = 0;
    while (lock !== 1'b1 && n < max_cycles) begin
      idle_cycles(1);
      n++;
    end
    n_checks++;
    if (lock !== 1'b1) begin
      n_fails++;
      $display("FAIL lock wait expired after %0d cycles @%0t", max_cycles, $time);
    end
  endtask

  // Sends n full sweeps of the current configuration, optionally with random idle gaps.
  task automatic send_sweeps(input int n, input bit gaps);
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < 16; i++) begin
        if (gaps && $urandom_range(0, 3) == 0) idle_cycles(1);
        vld = 1'b1;
        idx = 4'(i);
        dat = (i < 9) ? 16'(cfg[i]) : 16'($urandom);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_reset_state("power-up");
    rst_n = 1'b1;

    // Stream with run low: everything stays quiet.
    set_cfg(10, 4, 3, 2, 6, 2, 2, 1, 3);
    send_sweeps(2, 1'b0);

    // Reference configuration, active-high syncs.
    run = 1'b1;
    send_sweeps(10, 1'b0);
    wait_lock(40);

    // Inverted polarities.
    cfg[8] = 0;
    send_sweeps(10, 1'b0);

    // New htotal lands mid-frame; swap only at frame end.
    cfg[8] = 3;
    send_sweeps(3, 1'b0);
    idle_cycles(7);
    cfg[0] = 12;
    send_sweeps(10, 1'b0);

    // Drop run mid-line, re-raise and relock on the next sweep.
    cfg[0] = 10;
    send_sweeps(5, 1'b0);
    idle_cycles(3);
    run = 1'b0;
    idle_cycles(4);
    run = 1'b1;
    idle_cycles(5);
    send_sweeps(8, 1'b0);
    wait_lock(40);

    // Randomized configurations with gaps and occasional run drops.
    for (int k = 0; k < 8; k++) begin
      set_cfg($urandom_range(0, 16), $urandom_range(0, 8), $urandom_range(0, 10),
              $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4),
              $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3));
      send_sweeps(8, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        run = 1'b0;
        idle_cycles($urandom_range(1, 4));
        run = 1'b1;
      end
    end

    // Asynchronous reset in the middle of a frame, then restart from scratch.
    set_cfg(10, 4, 3, 2, 6, 2, 2, 1, 3);
    send_sweeps(6, 1'b0);
    idle_cycles(13);
    #2 rst_n = 1'b0;
    #1 check_reset_state("mid-frame");
    @(negedge clk);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(4);
    send_sweeps(8, 1'b0);

    run = 1'b0;
    idle_cycles(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
